// File: rtl/alu_seq_if.sv
// Request/response bundle of the ALU execute unit.
// The slave modport is the execute unit; the master modport is the surrounding datapath.
interface alu_seq_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic [3:0]         ctrl_i;
    logic [DATA_W-1:0]  src1_i;
    logic [DATA_W-1:0]  src2_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [DATA_W-1:0]  result_o;
    logic               zero_o;
    logic               ovf_o;
    logic               err_o;
    logic               out_valid_o;
    logic               out_ready_i;

    modport slave (
        input  ctrl_i, src1_i, src2_i, shamt_i, in_valid_i, out_ready_i,
        output in_ready_o, result_o, zero_o, ovf_o, err_o, out_valid_o
    );

    modport master (
        output ctrl_i, src1_i, src2_i, shamt_i, in_valid_i, out_ready_i,
        input  in_ready_o, result_o, zero_o, ovf_o, err_o, out_valid_o
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execute unit: logic/add/sub/slt in one cycle, shifts iterate one bit per cycle.
// Defining ALU_SEQ_BARREL_EN swaps the iterative shifter for a single-cycle barrel shifter.
module alu_seq_exec #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input logic      clk_i,
    input logic      rst_i,
    alu_seq_if.slave bus
);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] { S_IDLE, S_SHIFT, S_DONE } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic               dir_q, dir_d;

    logic signed [DATA_W-1:0] op_a, op_b, sum, diff;
    logic [DATA_W-1:0]        alu_res, work_step;
    logic [SHAMT_W-1:0]       amt;
    logic                     alu_ovf, legal, is_shift, load_res;

    assign op_a      = bus.src1_i;
    assign op_b      = bus.src2_i;
    assign sum       = op_a + op_b;
    assign diff      = op_a - op_b;
    assign work_step = dir_q ? (work_q >> 1) : (work_q << 1);

    // Single-cycle result of the request on the bus; ctrl_i[0] selects right shifts
    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        legal    = 1'b1;
        is_shift = 1'b0;
        amt      = bus.shamt_i;
        case (bus.ctrl_i)
            4'b0000: alu_res = bus.src1_i & bus.src2_i;
            4'b0001: alu_res = bus.src1_i | bus.src2_i;
            4'b0010: begin
                alu_res = sum;
                alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            4'b0110: begin
                alu_res = diff;
                alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            4'b0111: alu_res = {{MSB{1'b0}}, (op_a < op_b)};
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                is_shift = 1'b1;
                if (bus.ctrl_i[1]) begin
                    amt = bus.src1_i[SHAMT_W-1:0];
                end
`ifdef ALU_SEQ_BARREL_EN
                alu_res = bus.ctrl_i[0] ? (bus.src2_i >> amt) : (bus.src2_i << amt);
`else
                alu_res = bus.src2_i;
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dir_d    = dir_q;
        load_res = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
`ifdef ALU_SEQ_BARREL_EN
                    load_res = 1'b1;
`else
                    if (is_shift && (amt != '0)) begin
                        work_d  = bus.src2_i;
                        cnt_d   = amt;
                        dir_d   = bus.ctrl_i[0];
                        state_d = S_SHIFT;
                    end else begin
                        load_res = 1'b1;
                    end
`endif
                end
            end
`ifndef ALU_SEQ_BARREL_EN
            S_SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    result_d = work_step;
                    zero_d   = (work_step == '0);
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load_res) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            err_d    = ~legal;
            state_d  = S_DONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Shift working register is pure datapath; its contents only matter while in SHIFT
    always_ff @(posedge clk_i) begin
        work_q <= work_d;
        dir_q  <= dir_d;
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.result_o    = result_q;
    assign bus.zero_o      = zero_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: behavioural model plus a per-cycle compare process.
module tb_alu_seq_exec;
`ifdef ALU_SEQ_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_seq_if #(.DATA_W(32), .SHAMT_W(5)) bus ();
    alu_seq_exec #(.DATA_W(32), .SHAMT_W(5)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver-owned expectation of the operation in flight
    logic        pend = 1'b0;
    int          op_id = 0;
    int          acc_edge = 0;
    int          exp_lat = 0;
    logic [31:0] exp_res = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_err = 1'b0;

    // Compare-process-owned observations
    int          cur_id = 0;
    logic        seen = 1'b0;
    logic        exp_idle = 1'b0;
    logic        finished = 1'b0;
    int          cap_lat = -1;
    logic [31:0] cap_res = '0;
    logic        cap_zero = 1'b0;
    logic        cap_ovf = 1'b0;
    logic        cap_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result, overflow, error and accept-to-valid latency from the instruction semantics
    task automatic model(input logic [3:0] c, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] sh, output logic [31:0] r, output logic ov,
                         output logic er, output int lat);
        longint sa, sb, full;
        int     amt;
        bit     shift_op;
        sa = longint'($signed(s1));
        sb = longint'($signed(s2));
        r = '0; ov = 1'b0; er = 1'b0; amt = 0; shift_op = 1'b0;
        case (c)
            4'b0000: r = s1 & s2;
            4'b0001: r = s1 | s2;
            4'b0010: begin
                full = sa + sb;
                r = full[31:0];
                ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'b0110: begin
                full = sa - sb;
                r = full[31:0];
                ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: begin amt = int'(sh);      r = s2 << amt; shift_op = 1'b1; end
            4'b1001: begin amt = int'(sh);      r = s2 >> amt; shift_op = 1'b1; end
            4'b1010: begin amt = int'(s1[4:0]); r = s2 << amt; shift_op = 1'b1; end
            4'b1011: begin amt = int'(s1[4:0]); r = s2 >> amt; shift_op = 1'b1; end
            default: er = 1'b1;
        endcase
        lat = (shift_op && !BARREL) ? amt + 1 : 1;
    endtask

    always @(negedge clk) begin
        if (op_id != cur_id) begin
            cur_id   = op_id;
            seen     = 1'b0;
            exp_idle = 1'b0;
            finished = 1'b0;
            cap_lat  = -1;
        end
        if (!rst && pend && !finished && (cyc >= acc_edge)) begin
            if (exp_idle) begin
                chk("return_idle", {62'd0, bus.out_valid_o, bus.in_ready_o}, 64'd1);
                finished = 1'b1;
            end else begin
                if (!seen) begin
                    if (bus.out_valid_o) begin
                        seen     = 1'b1;
                        cap_lat  = cyc - acc_edge + 1;
                        cap_res  = bus.result_o;
                        cap_zero = bus.zero_o;
                        cap_ovf  = bus.ovf_o;
                        cap_err  = bus.err_o;
                        chk("latency", cap_lat, exp_lat);
                    end else if (cyc >= acc_edge + exp_lat - 1) begin
                        chk("valid_rise", bus.out_valid_o, 1);
                        finished = 1'b1;
                    end else begin
                        chk("busy_ready", bus.in_ready_o, 0);
                    end
                end
                if (seen) begin
                    chk("result", {bus.result_o, bus.zero_o, bus.ovf_o, bus.err_o},
                        {exp_res, (exp_res == 32'd0), exp_ovf, exp_err});
                    chk("valid_held", {bus.out_valid_o, bus.in_ready_o}, 2'b10);
                    if (bus.out_ready_i) exp_idle = 1'b1;
                end
            end
        end
    end

    task automatic start(input logic [3:0] c, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] sh, input bit rdy);
        int n = 0;
        while (!bus.in_ready_o && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("ready_timeout", bus.in_ready_o, 1);
        model(c, s1, s2, sh, exp_res, exp_ovf, exp_err, exp_lat);
        bus.ctrl_i = c; bus.src1_i = s1; bus.src2_i = s2; bus.shamt_i = sh;
        bus.in_valid_i = 1'b1;
        bus.out_ready_i = rdy;
        acc_edge = cyc + 1;
        op_id++;
        pend = 1'b1;
        @(posedge clk); #1;
        // Scramble operands after the handshake; the unit must ignore them
        bus.in_valid_i = 1'b0;
        bus.ctrl_i = ~c;
        bus.src1_i = $urandom;
        bus.src2_i = $urandom;
        bus.shamt_i = ~sh;
    endtask

    task automatic run(input logic [3:0] c, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] sh, input int hold);
        int n = 0;
        start(c, s1, s2, sh, hold == 0);
        while (!bus.out_valid_o && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.out_valid_o) chk("valid_timeout", bus.out_valid_o, 1);
        repeat (hold) begin @(posedge clk); #1; end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic        o, e;
        int          l, nv;

        bus.ctrl_i = '0; bus.src1_i = '0; bus.src2_i = '0; bus.shamt_i = '0;
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {bus.in_ready_o, bus.out_valid_o, bus.result_o, bus.zero_o, bus.ovf_o, bus.err_o},
            {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", {bus.in_ready_o, bus.out_valid_o, bus.result_o, bus.zero_o},
            {1'b1, 1'b0, 32'h0, 1'b1});

        // Hand-computed pins of the model itself
        model(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, r, o, e, l);
        chk("model_add", {r, o, e, l[7:0]}, {32'h80000000, 1'b1, 1'b0, 8'd1});
        model(4'b0111, 32'hFFFFFFFE, 32'h3, 5'd0, r, o, e, l);
        chk("model_slt", r, 32'd1);
        model(4'b0110, 32'h80000000, 32'h1, 5'd0, r, o, e, l);
        chk("model_sub_ovf", {r, o}, {32'h7FFFFFFF, 1'b1});
        model(4'b1010, 32'd4, 32'hF, 5'd0, r, o, e, l);
        chk("model_sllv", {r, l[7:0]}, {32'hF0, (BARREL ? 8'd1 : 8'd5)});
        model(4'b1001, 32'd0, 32'h80000000, 5'd31, r, o, e, l);
        chk("model_srl31", {r, l[7:0]}, {32'h1, (BARREL ? 8'd1 : 8'd32)});
        model(4'b1111, 32'd7, 32'd9, 5'd0, r, o, e, l);
        chk("model_illegal", {r, e}, {32'h0, 1'b1});

        run(4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0);
        chk("add_ovf_lit", {cap_res, cap_ovf, cap_zero, cap_lat[7:0]}, {32'h80000000, 1'b1, 1'b0, 8'd1});
        run(4'b0111, 32'hFFFFFFFE, 32'h00000003, 5'd0, 0);
        chk("slt_neg_lit", cap_res, 32'd1);
        run(4'b0110, 32'd5, 32'd5, 5'd0, 0);
        chk("sub_zero_lit", {cap_res, cap_zero, cap_ovf}, {32'h0, 1'b1, 1'b0});
        run(4'b0110, 32'h80000000, 32'h00000001, 5'd0, 0);
        run(4'b0000, 32'hAAAA5555, 32'h0FF00FF0, 5'd0, 0);
        chk("and_lit", cap_res, 32'h0AA00550);
        run(4'b0001, 32'hAAAA5555, 32'h0FF00FF0, 5'd0, 0);
        run(4'b0111, 32'h7FFFFFFF, 32'h80000000, 5'd0, 0);
        chk("slt_ovf_lit", cap_res, 32'd0);
        run(4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 0);
        chk("add_wrap_lit", {cap_res, cap_zero, cap_ovf}, {32'h0, 1'b1, 1'b0});

        run(4'b1010, 32'd4, 32'h0000000F, 5'd0, 3);
        chk("sllv_bp_lit", {cap_res, cap_lat[7:0]}, {32'h000000F0, (BARREL ? 8'd1 : 8'd5)});
        run(4'b1001, 32'd0, 32'h80000000, 5'd0, 0);
        chk("srl0_lit", {cap_res, cap_lat[7:0]}, {32'h80000000, 8'd1});
        run(4'b1001, 32'd0, 32'h80000000, 5'd31, 0);
        chk("srl31_lit", {cap_res, cap_lat[7:0]}, {32'h00000001, (BARREL ? 8'd1 : 8'd32)});
        run(4'b1000, 32'd31, 32'h00000001, 5'd3, 1);
        chk("sll3_lit", cap_res, 32'h8);
        run(4'b1011, 32'hFFFFFFE4, 32'h000000F0, 5'd0, 0);
        chk("srlv_mask_lit", cap_res, 32'hF);
        run(4'b1010, 32'd1, 32'h80000000, 5'd9, 0);
        chk("sllv_out_lit", {cap_res, cap_zero}, {32'h0, 1'b1});

        // Reset while a long shift (or a held result) is in flight
        start(4'b1011, 32'd20, 32'hFFFF0000, 5'd0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        pend = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_mid_op", {bus.in_ready_o, bus.out_valid_o, bus.result_o, bus.zero_o, bus.ovf_o, bus.err_o},
            {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
        nv = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.out_valid_o) nv++;
        end
        chk("no_valid_after_reset", nv, 0);

        run(4'b1111, 32'h12345678, 32'h9ABCDEF0, 5'd0, 0);
        chk("illegal_lit", {cap_res, cap_err, cap_lat[7:0]}, {32'h0, 1'b1, 8'd1});
        run(4'b0011, 32'h1, 32'h2, 5'd0, 2);
        run(4'b0001, 32'h00000100, 32'h00000001, 5'd0, 0);
        chk("err_clears_lit", {cap_res, cap_err}, {32'h101, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
